// File: rtl/system_sysid_checker.sv
// system_sysid_checker: reads sysid words 0/1 over Avalon-MM, compares to build constants, flags mismatch/timeout
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1395606384,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);
  typedef enum logic [3:0] {IDLE, RD_ID, GAP_ID, LAT_ID, RD_TS, GAP_TS, LAT_TS, CMP, DONE} state_t;
  localparam logic [15:0] TMO     = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRIES = 4'(MAX_RETRIES);
  localparam logic [1:0]  LAT     = 2'(READ_LATENCY);
  localparam bit          NO_LAT  = READ_LATENCY == 0;
  state_t      state, state_nxt;
  logic [15:0] stall_cnt;
  logic [3:0]  retry_cnt;
  logic [1:0]  lat_cnt;
  logic        accept, tmo, retry, give_up, go, lat_done, cap_id, cap_ts;
  assign avm_read    = state == RD_ID || state == RD_TS;
  assign avm_address = state == RD_TS;
  assign busy        = state != IDLE && state != DONE;
  assign accept      = avm_read & ~avm_waitrequest;
  // accept on the timeout cycle wins because tmo requires waitrequest still high
  assign tmo         = avm_read & avm_waitrequest & (stall_cnt == TMO);
  assign retry       = tmo & (retry_cnt < RETRIES);
  assign give_up     = tmo & ~retry;
  assign go          = (state == IDLE && (AUTO_START || start)) || (state == DONE && start);
  assign lat_done    = lat_cnt == LAT;
  assign cap_id      = (state == RD_ID && accept && NO_LAT) || (state == LAT_ID && lat_done);
  assign cap_ts      = (state == RD_TS && accept && NO_LAT) || (state == LAT_TS && lat_done);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = go ? RD_ID : state;
      RD_ID:      state_nxt = accept ? (NO_LAT ? RD_TS : LAT_ID) : retry ? GAP_ID : give_up ? DONE : RD_ID;
      GAP_ID:     state_nxt = RD_ID;
      LAT_ID:     state_nxt = lat_done ? RD_TS : LAT_ID;
      RD_TS:      state_nxt = accept ? (NO_LAT ? CMP : LAT_TS) : retry ? GAP_TS : give_up ? DONE : RD_TS;
      GAP_TS:     state_nxt = RD_TS;
      LAT_TS:     state_nxt = lat_done ? CMP : LAT_TS;
      CMP:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt   <= '0;
      retry_cnt   <= '0;
      lat_cnt     <= '0;
      read_id     <= '0;
      read_ts     <= '0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt   <= (avm_read && avm_waitrequest && !tmo) ? stall_cnt + 16'd1 : '0;
      retry_cnt   <= go ? '0 : retry ? retry_cnt + 4'd1 : retry_cnt;
      lat_cnt     <= accept ? 2'd1 : lat_cnt + 2'd1;
      read_id     <= cap_id ? avm_readdata : read_id;
      read_ts     <= cap_ts ? avm_readdata : read_ts;
      done        <= state_nxt == DONE;
      id_ok       <= go ? 1'b0 : state == CMP ? read_id == EXPECTED_ID : id_ok;
      ts_ok       <= go ? 1'b0 : state == CMP ? read_ts == EXPECTED_TS : ts_ok;
      timeout_err <= go ? 1'b0 : give_up ? 1'b1 : timeout_err;
    end
  end
endmodule

// File: tb/tb_system_sysid_checker.sv
// tb_system_sysid_checker: directed vectors and corner sequences for system_sysid_checker
module tb_system_sysid_checker;
  localparam logic [31:0] TS  = 32'd1395606384;
  localparam logic [31:0] IDB = 32'hCAFE0001;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic        rst_a, start_a, addr_a, rd_a, busy_a, done_a, iok_a, tok_a, terr_a;
  logic        wr_a = 1'b0;
  logic [31:0] data_a, rid_a, rts_a, id_a, ts_a;
  assign data_a = addr_a ? ts_a : id_a;
  system_sysid_checker u_a (
    .clock(clk), .reset_n(rst_a), .start(start_a), .avm_address(addr_a), .avm_read(rd_a),
    .avm_waitrequest(wr_a), .avm_readdata(data_a), .busy(busy_a), .done(done_a), .id_ok(iok_a),
    .ts_ok(tok_a), .timeout_err(terr_a), .read_id(rid_a), .read_ts(rts_a));
  logic        rst_b, start_b, addr_b, rd_b, wr_b, busy_b, done_b, iok_b, tok_b, terr_b;
  logic [31:0] data_b, rid_b, rts_b, id_b, ts_b;
  logic        p1v = 1'b0, p1a = 1'b0, p2v = 1'b0, p2a = 1'b0;
  always @(posedge clk) begin
    p1v <= rd_b & ~wr_b;
    p1a <= addr_b;
    p2v <= p1v;
    p2a <= p1a;
  end
  assign data_b = p2v ? (p2a ? ts_b : id_b) : 32'hDEADBEEF;
  system_sysid_checker #(.EXPECTED_ID(IDB), .READ_LATENCY(2), .TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) u_b (
    .clock(clk), .reset_n(rst_b), .start(start_b), .avm_address(addr_b), .avm_read(rd_b),
    .avm_waitrequest(wr_b), .avm_readdata(data_b), .busy(busy_b), .done(done_b), .id_ok(iok_b),
    .ts_ok(tok_b), .timeout_err(terr_b), .read_id(rid_b), .read_ts(rts_b));
  logic        rst_c, start_c, addr_c, rd_c, wr_c, busy_c, done_c, iok_c, tok_c, terr_c;
  logic [31:0] data_c, rid_c, rts_c;
  assign data_c = addr_c ? TS : 32'd0;
  system_sysid_checker #(.AUTO_START(1'b0)) u_c (
    .clock(clk), .reset_n(rst_c), .start(start_c), .avm_address(addr_c), .avm_read(rd_c),
    .avm_waitrequest(wr_c), .avm_readdata(data_c), .busy(busy_c), .done(done_c), .id_ok(iok_c),
    .ts_ok(tok_c), .timeout_err(terr_c), .read_id(rid_c), .read_ts(rts_c));
  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        iok;
    logic        tok;
  } vec_t;
  vec_t vt[5];
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", n, act, exp);
    end
  endtask
  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  function automatic logic dn(input int s);
    return s == 0 ? done_a : s == 1 ? done_b : done_c;
  endfunction
  task automatic wait_done(input int s, input int max, output int cyc);
    cyc = 0;
    while (!dn(s) && cyc < max) begin
      tick;
      cyc++;
    end
    chk("done_seen", dn(s), 1'b1);
  endtask
  initial begin
    int cyc, att;
    logic prev;
    vt[0] = '{32'd0, TS, 1'b1, 1'b1};
    vt[1] = '{32'd0, 32'h12345678, 1'b1, 1'b0};
    vt[2] = '{32'd5, TS, 1'b0, 1'b1};
    vt[3] = '{32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
    vt[4] = '{32'd0, TS + 32'd1, 1'b1, 1'b0};
    {rst_a, rst_b, rst_c, start_a, start_b, start_c, wr_b, wr_c} = '0;
    id_a = 32'd0; ts_a = TS; id_b = IDB; ts_b = TS;
    tick;
    tick;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_read", rd_a, 1'b0);
    chk("rst_idok", iok_a, 1'b0);
    chk32("rst_rid", rid_a, 32'd0);
    {rst_a, rst_b, rst_c} = 3'b111;
    tick;
    chk("t1_rd_id", rd_a, 1'b1);
    chk("t1_addr0", addr_a, 1'b0);
    chk("t1_busy", busy_a, 1'b1);
    tick;
    chk("t1_rd_ts", rd_a, 1'b1);
    chk("t1_addr1", addr_a, 1'b1);
    tick;
    chk("t1_cmp_nodone", done_a, 1'b0);
    chk("t1_cmp_noread", rd_a, 1'b0);
    tick;
    chk("t1_done4", done_a, 1'b1);
    chk("t1_idok", iok_a, 1'b1);
    chk("t1_tsok", tok_a, 1'b1);
    chk("t1_idle_busy", busy_a, 1'b0);
    chk("t1_terr", terr_a, 1'b0);
    chk("t5_no_auto_busy", busy_c, 1'b0);
    chk("t5_no_auto_done", done_c, 1'b0);
    wait_done(1, 20, cyc);
    chk("b_auto_idok", iok_b, 1'b1);
    for (int i = 0; i < 5; i++) begin
      id_a = vt[i].id;
      ts_a = vt[i].ts;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      chk("v_clr_done", done_a, 1'b0);
      chk("v_clr_idok", iok_a, 1'b0);
      tick;
      tick;
      chk("v_early", done_a, 1'b0);
      tick;
      chk("v_done", done_a, 1'b1);
      chk("v_idok", iok_a, vt[i].iok);
      chk("v_tsok", tok_a, vt[i].tok);
      chk32("v_rid", rid_a, vt[i].id);
      chk32("v_rts", rts_a, vt[i].ts);
      chk("v_terr", terr_a, 1'b0);
    end
    wr_b = 1'b1;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    cyc = 0; att = 0; prev = 1'b0;
    while (!done_b && cyc < 40) begin
      if (rd_b && !prev) att++;
      prev = rd_b;
      tick;
      cyc++;
    end
    chk32("t3_cycles", 32'(cyc), 32'd17);
    chk32("t3_attempts", 32'(att), 32'd3);
    chk("t3_terr", terr_b, 1'b1);
    chk("t3_idok", iok_b, 1'b0);
    chk("t3_tsok", tok_b, 1'b0);
    chk("t3_busy", busy_b, 1'b0);
    chk32("t3_rid_kept", rid_b, IDB);
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    chk("t4_terr_clr", terr_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rd_hold", rd_b, 1'b1);
      chk("t4_addr_hold", addr_b, 1'b0);
      tick;
    end
    chk("t4_rd_edge", rd_b, 1'b1);
    chk("t4_addr_edge", addr_b, 1'b0);
    wr_b = 1'b0;
    tick;
    chk("t4_rd_drop", rd_b, 1'b0);
    wait_done(1, 20, cyc);
    chk32("t4_cycles", 32'(cyc), 32'd6);
    chk("t4_idok", iok_b, 1'b1);
    chk("t4_tsok", tok_b, 1'b1);
    chk("t4_terr", terr_b, 1'b0);
    chk32("t4_rid", rid_b, IDB);
    chk32("t4_rts", rts_b, TS);
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    repeat (4) tick;
    chk("t6_busy", busy_b, 1'b1);
    chk("t6_lat_rd", rd_b, 1'b0);
    chk32("t6_rid_cap", rid_b, IDB);
    rst_b = 1'b0;
    #1;
    chk("t6_busy0", busy_b, 1'b0);
    chk("t6_done0", done_b, 1'b0);
    chk("t6_rd0", rd_b, 1'b0);
    chk32("t6_rid0", rid_b, 32'd0);
    chk32("t6_rts0", rts_b, 32'd0);
    tick;
    rst_b = 1'b1;
    wait_done(1, 20, cyc);
    chk32("t6_cycles", 32'(cyc), 32'd8);
    chk("t6_idok", iok_b, 1'b1);
    chk("t6_tsok", tok_b, 1'b1);
    chk32("t6_rts", rts_b, TS);
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    chk("t5_busy", busy_c, 1'b1);
    tick;
    wr_c = 1'b1;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    chk("t5_ignored_rd", rd_c, 1'b1);
    chk("t5_ignored_addr", addr_c, 1'b1);
    tick;
    chk("t5_still_ts", addr_c, 1'b1);
    wr_c = 1'b0;
    tick;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    chk("t5_done", done_c, 1'b1);
    tick;
    tick;
    chk("t5_no_queue_done", done_c, 1'b1);
    chk("t5_no_queue_busy", busy_c, 1'b0);
    chk("t5_idok", iok_c, 1'b1);
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    chk("t5_done_clr", done_c, 1'b0);
    wait_done(2, 20, cyc);
    chk32("t5_cycles", 32'(cyc), 32'd3);
    chk("t5_tsok", tok_c, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
